// File: rtl/sum_window_avg.sv
// Windowed averager: accumulates 2^LOG2N accepted samples, then holds the window
// sum and truncated mean on a valid/ready output until the consumer takes them.
module sum_window_avg #(
  parameter int BITWIDTH = 8,
  parameter int LOG2N    = 3
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic                      iEn,
  input  logic                      iClr,
  input  logic [BITWIDTH:0]         iData,
  output logic                      oInReady,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [BITWIDTH+LOG2N:0]   oSum,
  output logic [BITWIDTH:0]         oMean,
  output logic [LOG2N-1:0]          oCnt
);

  localparam int SW = BITWIDTH + 1 + LOG2N;

  typedef enum logic {ACC, HOLD} state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         acc_q, acc_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [BITWIDTH:0]     mean_q, mean_d;
  logic [LOG2N-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]         sum_next;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    mean_d   = mean_q;
    cnt_d    = cnt_q;
    sum_next = acc_q + SW'(iData);

    if (iClr) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (iEn) begin
            // Window completes when the counter is all ones (N-1)
            if (&cnt_q) begin
              sum_d   = sum_next;
              mean_d  = sum_next[SW-1:LOG2N];
              acc_d   = '0;
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              acc_d = sum_next;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (iReady) state_d = ACC;
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= ACC;
      acc_q   <= '0;
      sum_q   <= '0;
      mean_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      mean_q  <= mean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oValid   = (state_q == HOLD);
  assign oInReady = !oValid;
  assign oSum     = sum_q;
  assign oMean    = mean_q;
  assign oCnt     = cnt_q;

endmodule

// File: tb/tb_sum_window_avg.sv
// Directed bench for sum_window_avg (BITWIDTH=8, LOG2N=3) with hand-computed expectations.
module tb_sum_window_avg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [8:0]  data;
  logic        in_ready;
  logic        valid;
  logic        ready;
  logic [11:0] sum;
  logic [8:0]  mean;
  logic [2:0]  cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sum_window_avg #(.BITWIDTH(8), .LOG2N(3)) dut (
    .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr), .iData(data),
    .oInReady(in_ready), .oValid(valid), .iReady(ready),
    .oSum(sum), .oMean(mean), .oCnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int unsigned d);
    en   = 1'b1;
    data = 9'(d);
    step();
    en   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"},    valid,    0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_sum"},      sum,      0);
    check({tag, "_mean"},     mean,     0);
    check({tag, "_cnt"},      cnt,      0);
  endtask

  task automatic take();
    ready = 1'b1;
    step();
    check("take_valid", valid, 0);
    check("take_in_ready", in_ready, 1);
    ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; data = '0; ready = 1'b0;
    step(); step();
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Steady window with iEn and iReady held high
    ready = 1'b1;
    en    = 1'b1;
    data  = 9'd30;
    for (int unsigned i = 1; i <= 8; i++) begin
      step();
      if (i < 8) begin
        check("steady_cnt", cnt, i);
        check("steady_valid_low", valid, 0);
      end
    end
    check("steady_valid", valid, 1);
    check("steady_in_ready", in_ready, 0);
    check("steady_sum", sum, 240);
    check("steady_mean", mean, 30);
    check("steady_cnt_wrap", cnt, 0);
    step();
    check("steady_valid_1cyc", valid, 0);
    check("steady_bubble_cnt", cnt, 0);
    step();
    check("steady_next_cnt", cnt, 1);
    en = 1'b0; ready = 1'b0;
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_cnt", cnt, 0);

    // Backpressure
    for (int unsigned i = 0; i < 8; i++) feed(30);
    check("bp_valid", valid, 1);
    en = 1'b1; data = 9'd99;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", valid, 1);
      check("bp_hold_sum", sum, 240);
      check("bp_hold_mean", mean, 30);
      check("bp_in_ready", in_ready, 0);
      check("bp_cnt", cnt, 0);
    end
    en = 1'b0;
    take();
    check("bp_after_cnt", cnt, 0);

    // Truncation: 1..8
    for (int unsigned i = 1; i <= 8; i++) feed(i);
    check("trunc_valid", valid, 1);
    check("trunc_sum", sum, 36);
    check("trunc_mean", mean, 4);
    take();

    // Maximum sample value
    for (int unsigned i = 0; i < 8; i++) feed(511);
    check("max_valid", valid, 1);
    check("max_sum", sum, 4088);
    check("max_mean", mean, 511);
    take();

    // Gapped input: iEn high on odd cycles, 8th accept on cycle 15
    data = 9'd10;
    for (int unsigned c = 1; c <= 15; c++) begin
      en = (c % 2 == 1);
      step();
      check("gap_valid", valid, (c == 15) ? 1 : 0);
    end
    en = 1'b0;
    check("gap_sum", sum, 80);
    check("gap_mean", mean, 10);
    take();

    // Clear mid-window, offered sample dropped
    for (int unsigned i = 0; i < 5; i++) feed(30);
    check("clr_mid_cnt_pre", cnt, 5);
    clr = 1'b1; en = 1'b1; data = 9'd30;
    step();
    clr = 1'b0; en = 1'b0;
    check("clr_mid_cnt", cnt, 0);
    check("clr_mid_valid", valid, 0);
    for (int unsigned i = 0; i < 7; i++) feed(30);
    check("clr_fresh_not_done", valid, 0);
    check("clr_fresh_cnt", cnt, 7);
    feed(30);
    check("clr_fresh_valid", valid, 1);
    check("clr_fresh_sum", sum, 240);

    // Clear while a result is pending with iReady high
    clr = 1'b1; ready = 1'b1;
    step();
    clr = 1'b0; ready = 1'b0;
    check("clr_hold_valid", valid, 0);
    check("clr_hold_cnt", cnt, 0);
    check("clr_hold_in_ready", in_ready, 1);

    // Reset mid-window
    for (int unsigned i = 0; i < 3; i++) feed(50);
    check("rst_mid_cnt_pre", cnt, 3);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check_reset_vals("rst_mid");
    for (int unsigned i = 0; i < 8; i++) feed(20);
    check("rst_mid_no_stale_sum", sum, 160);

    // Reset during HOLD
    take();
    for (int unsigned i = 0; i < 8; i++) feed(100);
    check("rst_hold_valid_pre", valid, 1);
    check("rst_hold_sum_pre", sum, 800);
    check("rst_hold_mean_pre", mean, 100);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check_reset_vals("rst_hold");

    // Reset held low with iEn high
    rst_n = 1'b0; en = 1'b1; data = 9'd7; ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check_reset_vals("rst_held");
    end
    rst_n = 1'b1; en = 1'b0; ready = 1'b0;
    feed(7);
    check("post_rst_cnt", cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
